// File: rtl/aes_dec_ark_stage.sv
// ---------------------------------------------------------------------------
// aes_dec_ark_stage
//
// AddRoundKey stage of an iterative AES-256 decryption datapath. It sits
// directly upstream of inverseMixColumns.
//
// For each block the stage walks the round-key index from NR down to 0. It
// XORs the matching round key into the incoming state and registers the
// result. Each output beat is tagged so downstream logic knows whether to
// apply inverseMixColumns (middle rounds) or bypass it (rounds NR and 0).
//
// The output register plus one skid entry form a 2-entry elastic buffer.
// This sustains one beat per clock, while s_ready_o stays a registered
// signal.
//
// Optional feature macro: AES_ARK_STATS_EN
//   When defined, the stage adds the blk_done_cnt_o output: a 16-bit
//   wrapping count of completed final-round (m_last) beats.
//
// Parameters
//   NR          number of cipher rounds; the key index runs NR..0
//   KEY_IDX_W   key-store index width; 2**KEY_IDX_W must exceed NR
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   s_valid_i       upstream beat valid
//   s_ready_o       stage can accept a beat (registered)
//   s_state_i       128-bit state, byte 0 in [127:120], column-major
//   s_first_i       beat is the first of a block (ciphertext)
//   key_idx_o       round-key index presented to the key store
//   key_in_i        round key for key_idx_o, same cycle
//   m_valid_o       output beat valid
//   m_ready_i       downstream accepts the beat
//   m_state_o       registered s_state_i ^ key_in_i
//   m_round_o       key index used for this beat
//   m_mix_o         1: apply inverseMixColumns downstream, 0: bypass
//   m_last_o        beat is the final plaintext (round 0)
//   err_pulse_o     one-cycle pulse after a protocol error
//   blk_done_cnt_o  (AES_ARK_STATS_EN only) completed-block counter
// ---------------------------------------------------------------------------
module aes_dec_ark_stage #(
  parameter int NR        = 14,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [127:0]         s_state_i,
  input  logic                 s_first_i,
  output logic [KEY_IDX_W-1:0] key_idx_o,
  input  logic [127:0]         key_in_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [127:0]         m_state_o,
  output logic [KEY_IDX_W-1:0] m_round_o,
  output logic                 m_mix_o,
  output logic                 m_last_o,
  output logic                 err_pulse_o
`ifdef AES_ARK_STATS_EN
  ,
  output logic [15:0]          blk_done_cnt_o
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [KEY_IDX_W-1:0] KEY_NR  = KEY_IDX_W'(NR);
  localparam logic [KEY_IDX_W-1:0] KEY_ONE = KEY_IDX_W'(1);

  // Sequencer state
  logic [0:0]           state_q, state_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic                 err_q, err_d;
  logic                 s_ready_q, s_ready_d;

  // Output register (first buffer entry)
  logic                 out_valid_q, out_valid_d;
  logic [127:0]         out_state_q, out_state_d;
  logic [KEY_IDX_W-1:0] out_round_q, out_round_d;
  logic                 out_mix_q, out_mix_d;
  logic                 out_last_q, out_last_d;

  // Skid entry (second buffer entry)
  logic                 skid_valid_q, skid_valid_d;
  logic [127:0]         skid_state_q, skid_state_d;
  logic [KEY_IDX_W-1:0] skid_round_q, skid_round_d;
  logic                 skid_mix_q, skid_mix_d;
  logic                 skid_last_q, skid_last_d;

  // Combinational beat decode
  logic                 accept;
  logic                 drop;
  logic                 fwd;
  logic                 restart;
  logic                 out_fire;
  logic [KEY_IDX_W-1:0] cur_key;
  logic [127:0]         new_state;
  logic                 new_mix;
  logic                 new_last;

  // Key selection.
  // A beat with s_first always starts a block with key NR. This holds even
  // when it arrives mid-block, so key_in_i already carries the NR key in
  // the cycle the restart beat is accepted.
  always_comb begin
    restart   = (state_q == ST_RUN) && s_first_i;
    cur_key   = ((state_q == ST_IDLE) || s_first_i) ? KEY_NR : rnd_q;
    accept    = s_valid_i && s_ready_q;
    drop      = (state_q == ST_IDLE) && !s_first_i;
    fwd       = accept && !drop;
    out_fire  = out_valid_q && m_ready_i;
    new_state = s_state_i ^ key_in_i;
    new_mix   = (cur_key != KEY_NR) && (cur_key != '0);
    new_last  = (cur_key == '0);
  end

  assign key_idx_o = cur_key;

  // Round sequencer.
  // Round 0 always returns to IDLE, so the counter cannot underflow. A beat
  // that arrives in IDLE without s_first is discarded and flagged.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    err_d   = 1'b0;
    if (accept) begin
      if (drop) begin
        err_d = 1'b1;
      end else begin
        err_d = restart;
        if (cur_key == '0) begin
          state_d = ST_IDLE;
          rnd_d   = '0;
        end else begin
          state_d = ST_RUN;
          rnd_d   = cur_key - KEY_ONE;
        end
      end
    end
  end

  // Two-entry elastic buffer.
  // When the output slot frees up, it refills from the skid entry if that
  // entry is occupied, otherwise from the incoming beat. A beat that
  // arrives while the output is stalled parks in the skid entry. s_ready
  // falls on the same edge that the skid entry fills.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_state_d  = out_state_q;
    out_round_d  = out_round_q;
    out_mix_d    = out_mix_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_state_d = skid_state_q;
    skid_round_d = skid_round_q;
    skid_mix_d   = skid_mix_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_state_d  = skid_state_q;
        out_round_d  = skid_round_q;
        out_mix_d    = skid_mix_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (fwd) begin
        out_valid_d = 1'b1;
        out_state_d = new_state;
        out_round_d = cur_key;
        out_mix_d   = new_mix;
        out_last_d  = new_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (fwd) begin
      skid_valid_d = 1'b1;
      skid_state_d = new_state;
      skid_round_d = cur_key;
      skid_mix_d   = new_mix;
      skid_last_d  = new_last;
    end
    s_ready_d = !skid_valid_d;
  end

  // State registers; reset discards all in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rnd_q        <= '0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b1;
      out_valid_q  <= 1'b0;
      out_state_q  <= '0;
      out_round_q  <= '0;
      out_mix_q    <= 1'b0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_state_q <= '0;
      skid_round_q <= '0;
      skid_mix_q   <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      err_q        <= err_d;
      s_ready_q    <= s_ready_d;
      out_valid_q  <= out_valid_d;
      out_state_q  <= out_state_d;
      out_round_q  <= out_round_d;
      out_mix_q    <= out_mix_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_state_q <= skid_state_d;
      skid_round_q <= skid_round_d;
      skid_mix_q   <= skid_mix_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = out_valid_q;
  assign m_state_o   = out_state_q;
  assign m_round_o   = out_round_q;
  assign m_mix_o     = out_mix_q;
  assign m_last_o    = out_last_q;
  assign err_pulse_o = err_q;

`ifdef AES_ARK_STATS_EN
  logic [15:0] blk_done_cnt_q;

  // Counts completed final-round beats; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_done_cnt_q <= '0;
    end else if (out_fire && out_last_q) begin
      blk_done_cnt_q <= blk_done_cnt_q + 16'd1;
    end
  end

  assign blk_done_cnt_o = blk_done_cnt_q;
`endif

endmodule

// File: tb/tb_aes_dec_ark_stage.sv
module tb_aes_dec_ark_stage;

  localparam int NR = 14;
  localparam int KW = 4;
  localparam int BW = 128 + KW + 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic          sValid;
  logic          sReady;
  logic [127:0]  sState;
  logic          sFirst;
  logic [KW-1:0] keyIdx;
  logic [127:0]  keyIn;
  logic          mValid;
  logic          mReady;
  logic [127:0]  mState;
  logic [KW-1:0] mRound;
  logic          mMix;
  logic          mLast;
  logic          errPulse;
`ifdef AES_ARK_STATS_EN
  logic [15:0]   blkDone;
`endif

  // Key store: a plain table that the key index looks up combinationally
  logic [127:0] keyTab [16];
  assign keyIn = keyTab[keyIdx];

  always #5 clk = ~clk;

  aes_dec_ark_stage #(.NR(NR), .KEY_IDX_W(KW)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .s_valid_i  (sValid),
    .s_ready_o  (sReady),
    .s_state_i  (sState),
    .s_first_i  (sFirst),
    .key_idx_o  (keyIdx),
    .key_in_i   (keyIn),
    .m_valid_o  (mValid),
    .m_ready_i  (mReady),
    .m_state_o  (mState),
    .m_round_o  (mRound),
    .m_mix_o    (mMix),
    .m_last_o   (mLast),
    .err_pulse_o(errPulse)
`ifdef AES_ARK_STATS_EN
    ,
    .blk_done_cnt_o(blkDone)
`endif
  );

  int checksTotal = 0;
  int checksPassed = 0;

  // Behavioural model: the queue holds beats accepted and not yet completed
  logic [BW-1:0] q[$];
  bit            mIdle;
  int            mRnd;
  bit            mErr;
  logic [15:0]   blkCnt;
  bit            expReady;
  bit            expValid;
  bit            expErr;
  logic [KW-1:0] expKey;
  logic [BW-1:0] expBeat;

  logic [7:0] sboxTab [256];
  logic [7:0] invSboxTab [256];

  task automatic modelReset();
    q.delete();
    mIdle  = 1'b1;
    mRnd   = 0;
    mErr   = 1'b0;
    blkCnt = '0;
  endtask

  task automatic modelExpect();
    expReady = (q.size() < 2);
    expValid = (q.size() > 0);
    expErr   = mErr;
    expKey   = (mIdle || sFirst) ? KW'(NR) : KW'(mRnd);
    expBeat  = expValid ? q[0] : '0;
  endtask

  task automatic modelEdge();
    bit acc;
    int k;
    acc = sValid && (q.size() < 2);
    if (q.size() > 0 && mReady) begin
      if (q[0][0]) blkCnt = blkCnt + 16'd1;
      void'(q.pop_front());
    end
    mErr = 1'b0;
    if (acc) begin
      if (mIdle && !sFirst) begin
        mErr = 1'b1;
      end else begin
        k = (mIdle || sFirst) ? NR : mRnd;
        mErr = !mIdle && sFirst;
        q.push_back({sState ^ keyTab[k], KW'(k), 1'(k != NR && k != 0), 1'(k == 0)});
        if (k == 0) begin
          mIdle = 1'b1;
          mRnd  = 0;
        end else begin
          mIdle = 1'b0;
          mRnd  = k - 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit f, input logic [127:0] st, input bit r);
    sValid = v;
    sFirst = f;
    sState = st;
    mReady = r;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    rstN = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic loadIdxKeys();
    for (int i = 0; i < 16; i++) keyTab[i] = {16{8'(i)}};
  endtask

  task automatic loadRandKeys();
    for (int i = 0; i < 16; i++) keyTab[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [127:0] randState();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // GF(2^8) helpers for the AES reference path
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sboxTab[x] = s;
      invSboxTab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = invSboxTab[s[127 - 8 * i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  // AES-256 key expansion into the key table, round r at keyTab[r]
  task automatic loadAesKeys(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    for (int r = 0; r < 15; r++) keyTab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    keyTab[15] = '0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    rstN = 1'b0;
    modelReset();
    #3;
    checksTotal++;
    if ({sReady, mValid, mState, mRound, mMix, mLast, errPulse, keyIdx} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd14})
      $display("[TB] FAIL reset_values: got rdy=%b vld=%b st=%h rnd=%0d mix=%b last=%b err=%b key=%0d want rdy=1 vld=0 st=0 rnd=0 mix=0 last=0 err=0 key=14",
               sReady, mValid, mState, mRound, mMix, mLast, errPulse, keyIdx);
    else checksPassed++;
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checksTotal++;
    if ({sReady, mValid, errPulse} !== 3'b100)
      $display("[TB] FAIL reset_release: got rdy/vld/err=%b%b%b want 100", sReady, mValid, errPulse);
    else checksPassed++;
    @(posedge clk); #1;
  endtask

  task automatic test_one_block();
    int beats = 0;
    int lastAt = -1;
    applyReset();
    loadIdxKeys();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i < 15, i == 0, '0, 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL one_block ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL one_block beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      if (mValid) beats++;
      if (mValid && mLast) lastAt = beats;
      modelEdge();
      @(posedge clk); #1;
    end
    checksTotal++;
    if (beats !== 15 || lastAt !== 15)
      $display("[TB] FAIL one_block count: got beats=%0d last_at=%0d want beats=15 last_at=15", beats, lastAt);
    else checksPassed++;
  endtask

  task automatic test_stall_toggle();
    int accCnt = 0;
    int doneCnt = 0;
    bit sawLow = 1'b0;
    applyReset();
    loadRandKeys();
    for (int i = 0; i < 70; i++) begin
      if (i < 60) applyStimulus(1'b1, mIdle, randState(), (i % 2) == 0);
      else applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL stall ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL stall beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      if (sValid && expReady) accCnt++;
      if (mValid && mReady) doneCnt++;
      if (!sReady) sawLow = 1'b1;
      modelEdge();
      @(posedge clk); #1;
    end
    checksTotal++;
    if (doneCnt !== accCnt || sawLow !== 1'b1 || mValid !== 1'b0)
      $display("[TB] FAIL stall totals: got done=%0d low=%b vld=%b want done=%0d low=1 vld=0", doneCnt, sawLow, mValid, accCnt);
    else checksPassed++;
  endtask

  task automatic test_restart();
    int errCnt = 0;
    int outNo = 0;
    logic [KW+1:0] fifthTag = '0;
    applyReset();
    loadRandKeys();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(i < 19, (i == 0) || (i == 4), randState(), 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL restart ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL restart beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      if (errPulse) errCnt++;
      if (mValid) begin
        outNo++;
        if (outNo == 5) fifthTag = {mRound, mMix, mLast};
      end
      modelEdge();
      @(posedge clk); #1;
    end
    checksTotal++;
    if (errCnt !== 1 || fifthTag !== {4'd14, 1'b0, 1'b0} || outNo !== 19)
      $display("[TB] FAIL restart summary: got errs=%0d tag5=%b beats=%0d want errs=1 tag5=111000 beats=19", errCnt, fifthTag, outNo);
    else checksPassed++;
  endtask

  task automatic test_idle_drop();
    applyReset();
    loadIdxKeys();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 0, 1'b0, {16{8'hA5}}, 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL idle_drop ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      modelEdge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midblock();
    logic [KW-1:0] firstRound = '0;
    bit seen = 1'b0;
    applyReset();
    loadRandKeys();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, i == 0, randState(), i < 6);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL midreset ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL midreset beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      modelEdge();
      @(posedge clk); #1;
    end
    #2 rstN = 1'b0;
    modelReset();
    #1;
    checksTotal++;
    if ({sReady, mValid, mState, mRound, mMix, mLast, errPulse} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b0, 1'b0})
      $display("[TB] FAIL midreset async: got rdy=%b vld=%b st=%h rnd=%0d mix=%b last=%b err=%b want rdy=1 vld=0 st=0 rnd=0 mix=0 last=0 err=0",
               sReady, mValid, mState, mRound, mMix, mLast, errPulse);
    else checksPassed++;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < 19; i++) begin
      applyStimulus((i >= 2) && (i < 17), i == 2, randState(), 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL postreset ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL postreset beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      if (mValid && !seen) begin
        firstRound = mRound;
        seen = 1'b1;
      end
      modelEdge();
      @(posedge clk); #1;
    end
    checksTotal++;
    if (seen !== 1'b1 || firstRound !== 4'd14)
      $display("[TB] FAIL postreset first: got seen=%b round=%0d want seen=1 round=14", seen, firstRound);
    else checksPassed++;
  endtask

  task automatic test_back_to_back();
    applyReset();
    loadRandKeys();
    for (int i = 0; i < 250; i++) begin
      if (i < 40) applyStimulus(1'b1, mIdle, randState(), 1'b1);
      else if (i < 240)
        applyStimulus($urandom_range(0, 3) != 0,
                      mIdle ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 24) == 0),
                      randState(), $urandom_range(0, 3) != 0);
      else applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      modelExpect();
      checksTotal++;
      if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
        $display("[TB] FAIL b2b ctrl cyc %0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", i, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
      else checksPassed++;
      if (expValid) begin
        checksTotal++;
        if ({mState, mRound, mMix, mLast} !== expBeat)
          $display("[TB] FAIL b2b beat cyc %0d: got %h want %h", i, {mState, mRound, mMix, mLast}, expBeat);
        else checksPassed++;
      end
      modelEdge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fips_vector();
    logic [127:0] cur;
    applyReset();
    loadAesKeys(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    cur = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int r = NR; r >= 0; r--) begin
      for (int ph = 0; ph < 2; ph++) begin
        applyStimulus(ph == 0, (ph == 0) && (r == NR), cur, 1'b1);
        @(negedge clk);
        modelExpect();
        checksTotal++;
        if ({sReady, mValid, errPulse, keyIdx} !== {expReady, expValid, expErr, expKey})
          $display("[TB] FAIL fips ctrl r%0d p%0d: got rdy/vld/err/key=%b/%b/%b/%0d want %b/%b/%b/%0d", r, ph, sReady, mValid, errPulse, keyIdx, expReady, expValid, expErr, expKey);
        else checksPassed++;
        if (expValid) begin
          checksTotal++;
          if ({mState, mRound, mMix, mLast} !== expBeat)
            $display("[TB] FAIL fips beat r%0d: got %h want %h", r, {mState, mRound, mMix, mLast}, expBeat);
          else checksPassed++;
        end
        if (ph == 1) begin
          cur = mState;
          if (r != NR && r != 0) cur = invMixColumns(cur);
          if (r != 0) cur = invSubBytes(invShiftRows(cur));
        end
        modelEdge();
        @(posedge clk); #1;
      end
    end
    checksTotal++;
    if (cur !== 128'h00112233445566778899aabbccddeeff)
      $display("[TB] FAIL fips plaintext: got %h want 00112233445566778899aabbccddeeff", cur);
    else checksPassed++;
`ifdef AES_ARK_STATS_EN
    @(negedge clk);
    checksTotal++;
    if (blkDone !== 16'd1)
      $display("[TB] FAIL fips blk_done_cnt: got %0d want 1", blkDone);
    else checksPassed++;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) keyTab[i] = '0;
    modelReset();
    buildTables();
    @(posedge clk); #1;
    test_reset();
    test_one_block();
    test_stall_toggle();
    test_restart();
    test_idle_drop();
    test_reset_midblock();
    test_back_to_back();
    test_fips_vector();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
